// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 burst/response constants and the write-master FSM state encoding
package axi4_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;
endpackage

// File: rtl/axi4_burst_split.sv
// axi4_burst_split: beats for the next burst = min(remaining, MAX_BURST, beats left before the 4 KB page end); ports: offset (addr[11:0]), remaining in, blen out
module axi4_burst_split #(
  parameter int DATA_W = 256,
  parameter int CMD_BEATS_W = 16,
  parameter int LEN_W = 8,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]            offset,
  input  logic [CMD_BEATS_W-1:0] remaining,
  output logic [LEN_W:0]         blen
);
  localparam int SH = $clog2(DATA_W / 8);
  logic [12:0] room;
  logic [31:0] cap;
  always_comb begin
    room = (13'd4096 - {1'b0, offset}) >> SH;
    cap = 32'(room) < 32'(MAX_BURST) ? 32'(room) : 32'(MAX_BURST);
  end
  assign blen = (LEN_W + 1)'(32'(remaining) < cap ? 32'(remaining) : cap);
endmodule

// File: rtl/axi4_stream_wr_master.sv
// axi4_stream_wr_master: writes a valid/ready stream into AXI4 as INCR bursts; ports: cmd_* command, s_* stream, m_aw*/m_w*/m_b* AXI master, done_o/err_o completion
module axi4_stream_wr_master
  import axi4_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int MST_ID_W = 5,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_RESP_W = 2,
  parameter int CMD_BEATS_W = 16,
  parameter int MAX_BURST = 16,
  parameter int MST_ID = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           cmd_addr_i,
  input  logic [CMD_BEATS_W-1:0]      cmd_beats_i,
  input  logic                        cmd_vld_i,
  output logic                        cmd_rdy_o,
  input  logic [DATA_W-1:0]           s_data_i,
  input  logic                        s_vld_i,
  output logic                        s_rdy_o,
  output logic [MST_ID_W-1:0]         m_awid_o,
  output logic [ADDR_W-1:0]           m_awaddr_o,
  output logic [1:0]                  m_awburst_o,
  output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [DATA_W-1:0]           m_wdata_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [MST_ID_W-1:0]         m_bid_i,
  input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  output logic                        done_o,
  output logic                        err_o
);
  localparam int SH = $clog2(DATA_W / 8);
  localparam logic [TRANS_DATA_LEN_W:0] ONE = 1;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr, cmd_aligned;
  logic [CMD_BEATS_W-1:0] rem;
  logic [TRANS_DATA_LEN_W-1:0] len, cnt;
  logic [TRANS_DATA_LEN_W:0] blen, split_blen;
  logic blen_ok, err, cmd_hs, aw_hs, w_hs, b_hs, load_len;
  assign cmd_aligned = cmd_addr_i & ~ADDR_W'((1 << SH) - 1);
  assign blen = {1'b0, len} + ONE;
  // In IDLE the split sees the incoming command so AW can fire right after accept;
  // after a burst it sees the updated registers, costing one AW cycle with awvalid low.
  axi4_burst_split #(
    .DATA_W(DATA_W), .CMD_BEATS_W(CMD_BEATS_W), .LEN_W(TRANS_DATA_LEN_W), .MAX_BURST(MAX_BURST)
  ) u_split (
    .offset(state == ST_IDLE ? cmd_aligned[11:0] : addr[11:0]),
    .remaining(state == ST_IDLE ? cmd_beats_i : rem),
    .blen(split_blen)
  );
  assign cmd_rdy_o = state == ST_IDLE && !rst;
  assign m_awid_o = MST_ID_W'(MST_ID);
  assign m_awaddr_o = addr;
  assign m_awlen_o = len;
  assign m_awburst_o = state == ST_AW ? BURST_INCR : 2'b00;
  assign m_awvalid_o = state == ST_AW && blen_ok;
  assign m_wvalid_o = state == ST_W && s_vld_i;
  assign s_rdy_o = state == ST_W && m_wready_i;
  assign m_wdata_o = state == ST_W ? s_data_i : '0;
  assign m_wlast_o = state == ST_W && cnt == len;
  assign m_bready_o = state == ST_B;
  assign done_o = state == ST_DONE;
  assign err_o = state == ST_DONE && err;
  assign cmd_hs = cmd_rdy_o && cmd_vld_i;
  assign aw_hs = m_awvalid_o && m_awready_i;
  assign w_hs = m_wvalid_o && m_wready_i;
  assign b_hs = m_bready_o && m_bvalid_i;
  assign load_len = cmd_hs || (state == ST_AW && !blen_ok);
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: nxt = cmd_hs ? (cmd_beats_i == '0 ? ST_DONE : ST_AW) : ST_IDLE;
      ST_AW:   nxt = aw_hs ? ST_W : ST_AW;
      ST_W:    nxt = w_hs && m_wlast_o ? ST_B : ST_W;
      ST_B:    nxt = b_hs ? (rem == CMD_BEATS_W'(blen) ? ST_DONE : ST_AW) : ST_B;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr <= '0;
      rem <= '0;
      len <= '0;
      cnt <= '0;
      blen_ok <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (cmd_hs) begin
        addr <= cmd_aligned;
        rem <= cmd_beats_i;
        err <= 1'b0;
      end
      if (load_len) begin
        len <= TRANS_DATA_LEN_W'(split_blen - ONE);
        blen_ok <= 1'b1;
      end
      if (aw_hs) cnt <= '0;
      if (w_hs) cnt <= cnt + 1'b1;
      if (b_hs) begin
        err <= err | (m_bresp_i != TRANS_RESP_W'(RESP_OKAY)) | (m_bid_i != MST_ID_W'(MST_ID));
        addr <= addr + (ADDR_W'(blen) << SH);
        rem <= rem - CMD_BEATS_W'(blen);
        blen_ok <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi4_stream_wr_master.sv
// tb_axi4_stream_wr_master: table-driven commands against a behavioural AXI4 slave with burst/data scoreboards
module tb_axi4_stream_wr_master;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cmd_addr_i = '0;
  logic [15:0] cmd_beats_i = '0;
  logic cmd_vld_i = 1'b0, cmd_rdy_o;
  logic [255:0] s_data_i = '0;
  logic s_vld_i = 1'b0, s_rdy_o;
  logic [4:0] m_awid_o;
  logic [31:0] m_awaddr_o;
  logic [1:0] m_awburst_o;
  logic [7:0] m_awlen_o;
  logic m_awvalid_o, m_awready_i = 1'b0;
  logic [255:0] m_wdata_o;
  logic m_wlast_o, m_wvalid_o, m_wready_i = 1'b0;
  logic [4:0] m_bid_i = '0;
  logic [1:0] m_bresp_i = '0;
  logic m_bvalid_i = 1'b0, m_bready_o, done_o, err_o;

  axi4_stream_wr_master dut (
    .clk(clk), .rst(rst),
    .cmd_addr_i(cmd_addr_i), .cmd_beats_i(cmd_beats_i), .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .s_data_i(s_data_i), .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awburst_o(m_awburst_o), .m_awlen_o(m_awlen_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int beats;
    int err_burst;
    bit err_bid;
    bit gap;
    int bdly;
    bit bp;
    bit exp_err;
  } vec_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;

  vec_t tbl[8];
  aw_t exp_aw[$];
  logic [255:0] exp_w[$], stream_q[$], rb_d[$];
  logic [31:0] rb_a[$];
  logic [255:0] mem[logic [31:0]];
  int checks = 0, errors = 0;
  int err_burst = -1, bdly = 0, b_idx = 0, b_cnt = 0, beat = 0, gapchk = 0;
  int done_cnt = 0, aw_seen = 0, w_beats = 0;
  bit err_bid = 0, gap = 0, bp = 0, b_pend = 0, s_phase = 0;
  logic [31:0] cur_addr = '0;
  logic [7:0] cur_len = '0;
  aw_t e;

  task automatic check(input string n, input logic [255:0] a, input logic [255:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  // Stream source + AXI slave: drive on negedge, sample 1 ns before the next posedge.
  always @(negedge clk) begin
    s_vld_i = stream_q.size() > 0 && (!gap || s_phase);
    s_data_i = stream_q.size() > 0 ? stream_q[0] : '0;
    s_phase = !s_phase;
    m_awready_i = bp ? $urandom_range(0, 1) == 1 : 1'b1;
    m_wready_i = bp ? $urandom_range(0, 1) == 1 : 1'b1;
    m_bvalid_i = b_pend && b_cnt >= bdly;
    m_bresp_i = m_bvalid_i && b_idx == err_burst && !err_bid ? 2'b10 : 2'b00;
    m_bid_i = m_bvalid_i && b_idx == err_burst && err_bid ? 5'd3 : 5'd0;
    #4;
    if (rst) begin
      exp_aw.delete();
      exp_w.delete();
      stream_q.delete();
      b_pend = 0;
      gapchk = 0;
    end else begin
      if (done_o) done_cnt++;
      if (m_awvalid_o) aw_seen++;
      if (gapchk == 2) check("aw_gap_idle", m_awvalid_o, 0);
      if (gapchk == 1) check("aw_gap_resume", m_awvalid_o, 1);
      if (gapchk > 0) gapchk--;
      if (m_awvalid_o && m_awready_i) begin
        if (exp_aw.size() == 0) check("aw_unexpected", m_awaddr_o, 'x);
        else begin
          e = exp_aw.pop_front();
          check("awaddr", m_awaddr_o, e.addr);
          check("awlen", m_awlen_o, e.len);
          check("awburst", m_awburst_o, 2'b01);
          check("awid", m_awid_o, 0);
        end
        cur_addr = m_awaddr_o;
        cur_len = m_awlen_o;
        beat = 0;
      end
      if (s_vld_i && s_rdy_o) void'(stream_q.pop_front());
      if (m_wvalid_o && m_wready_i) begin
        if (exp_w.size() == 0) check("w_unexpected", m_wdata_o, 'x);
        else check("wdata", m_wdata_o, exp_w.pop_front());
        check("wlast", m_wlast_o, beat == int'(cur_len));
        mem[cur_addr + 32'(beat * 32)] = m_wdata_o;
        beat++;
        w_beats++;
        if (m_wlast_o) begin
          b_pend = 1;
          b_cnt = 0;
        end
      end else if (m_bvalid_i && m_bready_o) begin
        b_pend = 0;
        b_idx++;
        if (exp_aw.size() > 0) gapchk = 2;
      end else if (b_pend) b_cnt++;
    end
  end

  task automatic setup(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    logic [255:0] d;
    int r, b, room;
    a = addr & ~32'h1f;
    r = beats;
    rb_a.delete();
    rb_d.delete();
    while (r > 0) begin
      room = (4096 - int'(a & 32'hfff)) / 32;
      b = r < 16 ? r : 16;
      if (room < b) b = room;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int k = 0; k < b; k++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        stream_q.push_back(d);
        exp_w.push_back(d);
        rb_a.push_back(a + 32'(k * 32));
        rb_d.push_back(d);
      end
      a = a + 32'(b * 32);
      r -= b;
    end
  endtask

  task automatic issue(input logic [31:0] a, input int b);
    @(negedge clk);
    cmd_addr_i = a;
    cmd_beats_i = 16'(b);
    cmd_vld_i = 1'b1;
    #4;
    check("cmd_rdy", cmd_rdy_o, 1);
    @(negedge clk);
    cmd_vld_i = 1'b0;
    #4;
    check("aw_after_accept", m_awvalid_o, 1);
  endtask

  task automatic run_cmd(input vec_t v);
    int n, d0;
    err_burst = v.err_burst;
    err_bid = v.err_bid;
    gap = v.gap;
    bdly = v.bdly;
    bp = v.bp;
    b_idx = 0;
    d0 = done_cnt;
    setup(v.addr, v.beats);
    issue(v.addr, v.beats);
    n = 0;
    while (!done_o && n < 3000) begin
      @(negedge clk);
      #4;
      n++;
    end
    check("done_timeout", n < 3000, 1);
    check("err", err_o, v.exp_err);
    @(negedge clk);
    #4;
    check("done_pulse", done_o, 0);
    check("done_count", done_cnt - d0, 1);
    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_w.size(), 0);
    foreach (rb_a[i]) check("readback", mem.exists(rb_a[i]) ? mem[rb_a[i]] : 'x, rb_d[i]);
  endtask

  initial begin
    int n, a0, w0;
    tbl[0] = '{32'h0000_0000, 4, -1, 0, 0, 0, 0, 0};
    tbl[1] = '{32'h0000_0100, 40, -1, 0, 1, 5, 0, 0};
    tbl[2] = '{32'h0000_0F80, 8, -1, 0, 0, 0, 1, 0};
    tbl[3] = '{32'h0000_2000, 40, 1, 0, 0, 2, 0, 1};
    tbl[4] = '{32'h0000_0000, 4, -1, 0, 0, 0, 0, 0};
    tbl[5] = '{32'h0000_3000, 20, 0, 1, 1, 0, 1, 1};
    tbl[6] = '{32'h0000_010F, 3, -1, 0, 0, 1, 1, 0};
    tbl[7] = '{32'hFFFF_FFE0, 3, -1, 0, 1, 0, 0, 0};
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, s_rdy_o, done_o, err_o, cmd_rdy_o,
                       m_awburst_o, m_awlen_o, m_awaddr_o, m_awid_o}, 0);
    check("rst_wdata", m_wdata_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("idle_cmd_rdy", cmd_rdy_o, 1);
    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);
    a0 = aw_seen;
    @(negedge clk);
    cmd_beats_i = '0;
    cmd_vld_i = 1'b1;
    #4;
    check("zero_cmd_rdy", cmd_rdy_o, 1);
    @(negedge clk);
    cmd_vld_i = 1'b0;
    #4;
    check("zero_done", done_o, 1);
    check("zero_err", err_o, 0);
    @(negedge clk);
    #4;
    check("zero_done_pulse", done_o, 0);
    check("zero_no_aw", aw_seen - a0, 0);
    check("zero_back_idle", cmd_rdy_o, 1);
    gap = 1;
    bp = 0;
    bdly = 0;
    err_burst = -1;
    setup(32'h0000_4000, 16);
    w0 = w_beats;
    issue(32'h0000_4000, 16);
    n = 0;
    while (w_beats < w0 + 2 && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    check("w_started", n < 200, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midw_rst_ctrl", {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, s_rdy_o, done_o, err_o, cmd_rdy_o,
                            m_awburst_o, m_awlen_o, m_awaddr_o}, 0);
    check("midw_rst_wdata", m_wdata_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmd(tbl[1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
